// File: rtl/fifo_wr_ptr_if.sv
// Write-side bundle of the ADC->FT245 async FIFO: producer request, read-domain
// Gray pointer in, RAM strobe/address and status flags out.
interface fifo_wr_ptr_if #(
  parameter int unsigned ADDR_WIDTH = 10
);

  logic                  wr_en;
  logic [ADDR_WIDTH:0]   rd_gray;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH:0]   wr_gray;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   fill_level;
  logic                  overflow;

  modport master (
    output wr_en,
    output rd_gray,
    input  mem_we,
    input  wr_addr,
    input  wr_gray,
    input  full,
    input  almost_full,
    input  fill_level,
    input  overflow
  );

  modport slave (
    input  wr_en,
    input  rd_gray,
    output mem_we,
    output wr_addr,
    output wr_gray,
    output full,
    output almost_full,
    output fill_level,
    output overflow
  );

endinterface

// File: rtl/fifo_wr_ptr.sv
// Write-domain pointer/flag logic of the async sample FIFO: binary RAM address,
// Gray pointer export, read-pointer synchroniser and full/almost-full/level/overflow.
module fifo_wr_ptr #(
  parameter int unsigned ADDR_WIDTH         = 10,
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned ALMOST_FULL_THRESH = (1 << ADDR_WIDTH) - 4
) (
  input  logic          clk,
  input  logic          rst,
  fifo_wr_ptr_if.slave  bus
);

  localparam int unsigned   PW    = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AF_TH = PW'(ALMOST_FULL_THRESH);
  localparam logic [PW-1:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("fifo_wr_ptr: SYNC_STAGES must be 2..4");
    end
    if (ADDR_WIDTH < 2) begin : g_bad_addr
      $error("fifo_wr_ptr: ADDR_WIDTH must be at least 2");
    end
  endgenerate

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] rq;
  logic [PW-1:0] rbin;

  logic [PW-1:0] wbin;
  logic [PW-1:0] wgray_q;
  logic [PW-1:0] level_q;
  logic          full_q;
  logic          afull_q;
  logic          ovf_q;

  logic          accept;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] level_next;
  logic [PW-1:0] full_match;

  // Read-pointer synchroniser: rd_gray goes straight into the first flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= bus.rd_gray;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign rq = sync_q[SYNC_STAGES-1];

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin = '0;
    for (int unsigned i = 0; i < PW; i++) begin
      rbin[i] = ^(rq >> i);
    end
  end

  always_comb begin
    accept     = bus.wr_en & ~full_q & ~rst;
    wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, accept};
    wgray_next = wbin_next ^ (wbin_next >> 1);
    level_next = wbin_next - rbin;
    full_match = {~rq[PW-1:PW-2], rq[PW-3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin    <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin    <= wbin_next;
      wgray_q <= wgray_next;
      level_q <= level_next;
      full_q  <= (wgray_next == full_match);
      afull_q <= (level_next >= AF_TH);
      ovf_q   <= ovf_q | (bus.wr_en & full_q);
    end
  end

  assign bus.mem_we      = accept;
  assign bus.wr_addr     = wbin[ADDR_WIDTH-1:0];
  assign bus.wr_gray     = wgray_q;
  assign bus.full        = full_q;
  assign bus.almost_full = afull_q;
  assign bus.fill_level  = level_q;
  assign bus.overflow    = ovf_q;

  a_gray_step: assert property (@(posedge clk) disable iff (rst)
    !$past(rst) |-> ($countones(bus.wr_gray ^ $past(bus.wr_gray)) <= 1));

  a_level_bound: assert property (@(posedge clk) disable iff (rst)
    bus.fill_level <= DEPTH);

  a_ovf_sticky: assert property (@(posedge clk) disable iff (rst)
    (!$past(rst) && $past(bus.overflow)) |-> bus.overflow);

  a_no_write_full: assert property (@(posedge clk)
    bus.full |-> !bus.mem_we);

endmodule

// File: tb/tb_fifo_wr_ptr.sv
// Scoreboard bench for fifo_wr_ptr (ADDR_WIDTH=4): a count-based model predicts
// every cycle's outputs; a monitor pops and compares them.
module tb_fifo_wr_ptr;

  localparam int unsigned AW     = 4;
  localparam int unsigned SYNC   = 2;
  localparam int unsigned THRESH = 12;
  localparam int unsigned DEPTH  = 1 << AW;
  localparam int unsigned PMOD   = 2 * DEPTH;

  typedef struct {
    bit          mem_we;
    int unsigned addr;
    int unsigned gray;
    bit          full;
    bit          afull;
    int unsigned fill;
    bit          ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_wr_ptr_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wr_ptr #(
    .ADDR_WIDTH         (AW),
    .SYNC_STAGES        (SYNC),
    .ALMOST_FULL_THRESH (THRESH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t        exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;

  // Model state: counts of accepted writes / issued reads, plus the read
  // counts still travelling through the synchroniser.
  int unsigned total_w = 0;
  int unsigned total_r = 0;
  int unsigned synq[$];
  bit          m_full = 1'b0;
  bit          m_afull = 1'b0;
  int unsigned m_fill = 0;
  bit          m_ovf = 1'b0;

  function automatic int unsigned to_gray(input int unsigned v);
    int unsigned b;
    b = v % PMOD;
    return b ^ (b >> 1);
  endfunction

  function automatic void chk(input string nm, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endfunction

  task automatic model_reset();
    total_w = 0;
    total_r = 0;
    m_full  = 1'b0;
    m_afull = 1'b0;
    m_fill  = 0;
    m_ovf   = 1'b0;
    synq.delete();
    for (int i = 0; i < int'(SYNC); i++) synq.push_back(0);
  endtask

  task automatic model_edge(input bit r, input bit w, input int unsigned rd_now);
    int unsigned rq;
    int unsigned diff;
    bit          acc;
    if (r) begin
      model_reset();
      return;
    end
    acc = w && !m_full;
    if (w && m_full) m_ovf = 1'b1;
    rq = synq[SYNC-1];
    if (acc) total_w++;
    diff    = (total_w + PMOD - rq) % PMOD;
    m_fill  = diff;
    m_full  = (diff == DEPTH);
    m_afull = (diff >= THRESH);
    synq.push_front(rd_now);
    void'(synq.pop_back());
  endtask

  // One clock: drive at negedge, queue what the DUT must show now, advance model.
  task automatic cycle(input bit r, input bit w, input bit rd_adv);
    exp_t e;
    @(negedge clk);
    if (r) begin
      total_r = 0;
    end else if (rd_adv && total_r < total_w) begin
      total_r++;
    end
    rst        = r;
    bus.wr_en  = w;
    bus.rd_gray = (AW+1)'(to_gray(total_r));
    e.mem_we = w && !m_full && !r;
    e.addr   = total_w % DEPTH;
    e.gray   = to_gray(total_w);
    e.full   = m_full;
    e.afull  = m_afull;
    e.fill   = m_fill;
    e.ovf    = m_ovf;
    exp_q.push_back(e);
    model_edge(r, w, total_r % PMOD);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("mem_we",      32'(bus.mem_we),      32'(e.mem_we));
        chk("wr_addr",     32'(bus.wr_addr),     e.addr);
        chk("wr_gray",     32'(bus.wr_gray),     e.gray);
        chk("full",        32'(bus.full),        32'(e.full));
        chk("almost_full", 32'(bus.almost_full), 32'(e.afull));
        chk("fill_level",  32'(bus.fill_level),  e.fill);
        chk("overflow",    32'(bus.overflow),    32'(e.ovf));
      end
    end
  end

  initial begin : driver
    int unsigned waited;
    bus.wr_en   = 1'b0;
    bus.rd_gray = '0;
    model_reset();

    cycle(1, 0, 0);
    cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    for (int i = 0; i < 13; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0);

    cycle(0, 0, 1);
    for (int i = 0; i < int'(SYNC) + 2; i++) cycle(0, 0, 0);
    cycle(0, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);

    cycle(0, 1, 0);
    cycle(1, 1, 0);
    cycle(0, 1, 0);
    cycle(0, 0, 0);

    for (int i = 0; i < 4; i++) cycle(0, 0, 0);
    for (int i = 0; i < 40; i++) cycle(0, 1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      bit r;
      bit w;
      bit a;
      r = ($urandom_range(0, 127) == 0);
      w = (i < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      a = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) != 0);
      cycle(r, w, a);
    end
    cycle(0, 0, 0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
